// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-ported external memory between the
// instruction-fetch port (read-only) and the load/store port. Each access
// holds ext_en for MEM_LAT cycles, then the winning port gets a one-cycle ack.
// The load/store port normally wins ties. A starvation counter hands a tie to
// instruction fetch after STARVE_LIM consecutive losses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ext_en,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_CAP = 4'(STARVE_LIM);

    state_t            state;
    state_t            stateNext;
    logic              ownerMem;     // 0 = IF owns the access, 1 = MEM
    logic [3:0]        cnt;
    logic [3:0]        starve;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic              weReg;
    logic [DATA_W-1:0] ifRdataReg;
    logic [DATA_W-1:0] memRdataReg;
    logic              grantIf;
    logic              grantMem;

    // Arbitration decision; only meaningful while IDLE, request lines are ignored elsewhere
    always_comb begin
        grantIf  = 1'b0;
        grantMem = 1'b0;
        if (state == IDLE) begin
            if (if_req && mem_req) begin
                if (STARVE_LIM != 0 && starve == STARVE_CAP) grantIf = 1'b1;
                else                                         grantMem = 1'b1;
            end else if (mem_req) begin
                grantMem = 1'b1;
            end else if (if_req) begin
                grantIf = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantIf || grantMem) stateNext = ACCESS;
            ACCESS:  if (cnt == 4'd0)         stateNext = ACK;
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Grant latches, latency counter, starvation counter and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ownerMem    <= 1'b0;
            cnt         <= 4'd0;
            starve      <= 4'd0;
            addrReg     <= '0;
            wdataReg    <= '0;
            weReg       <= 1'b0;
            ifRdataReg  <= '0;
            memRdataReg <= '0;
        end else begin
            if (grantIf || grantMem) begin
                ownerMem <= grantMem;
                addrReg  <= grantMem ? mem_addr : if_addr;
                weReg    <= grantMem & mem_we;
                cnt      <= LAT_LAST;
                // IF never writes, so its grant keeps the previous write data
                if (grantMem) wdataReg <= mem_wdata;
            end
            if (grantIf) begin
                starve <= 4'd0;
            end else if (grantMem && if_req && starve != 4'hF) begin
                starve <= starve + 4'd1;
            end
            if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (!weReg) begin
                    if (ownerMem) memRdataReg <= ext_rdata;
                    else          ifRdataReg  <= ext_rdata;
                end
            end
        end
    end

    // Outputs decoded from state and the latched transaction
    always_comb begin
        ext_en    = (state == ACCESS);
        ext_we    = (state == ACCESS) && weReg;
        ext_addr  = addrReg;
        ext_wdata = wdataReg;
        if_ack    = (state == ACK) && !ownerMem;
        mem_ack   = (state == ACK) && ownerMem;
        if_rdata  = ifRdataReg;
        mem_rdata = memRdataReg;
        busy      = (state != IDLE);
        stall_if  = if_req && !if_ack;
        stall_mem = mem_req && !mem_ack;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a per-cycle vector table on a MEM_LAT=2,
// STARVE_LIM=3 instance, plus directed sequences for the starvation pattern,
// reset mid-access, and a MEM_LAT=1 / STARVE_LIM=0 instance.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: MEM_LAT=2, STARVE_LIM=3
    logic        rst, ifReq, memReq, memWe, ifAck, memAck, extEn, extWe;
    logic        stallIf, stallMem, busy;
    logic [15:0] ifAddr, memAddr, memWdata, ifRdata, memRdata;
    logic [15:0] extAddr, extWdata, extRdata;

    // Instance B: MEM_LAT=1, STARVE_LIM=0
    logic        bRst, bIfReq, bMemReq, bMemWe, bIfAck, bMemAck, bExtEn, bExtWe;
    logic        bStallIf, bStallMem, bBusy;
    logic [15:0] bIfAddr, bMemAddr, bMemWdata, bIfRdata, bMemRdata;
    logic [15:0] bExtAddr, bExtWdata, bExtRdata;

    // External memory model: fixed pattern at 0x0010, inverted address elsewhere
    assign extRdata  = (extAddr  == 16'h0010) ? 16'hA5A5 : ~extAddr;
    assign bExtRdata = (bExtAddr == 16'h0010) ? 16'hA5A5 : ~bExtAddr;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_LIM(3)) dutA (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
        .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .mem_ack(memAck),
        .ext_en(extEn), .ext_we(extWe), .ext_addr(extAddr), .ext_wdata(extWdata),
        .ext_rdata(extRdata),
        .stall_if(stallIf), .stall_mem(stallMem), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIM(0)) dutB (
        .clk(clk), .rst(bRst),
        .if_req(bIfReq), .if_addr(bIfAddr), .if_rdata(bIfRdata), .if_ack(bIfAck),
        .mem_req(bMemReq), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_rdata(bMemRdata), .mem_ack(bMemAck),
        .ext_en(bExtEn), .ext_we(bExtWe), .ext_addr(bExtAddr), .ext_wdata(bExtWdata),
        .ext_rdata(bExtRdata),
        .stall_if(bStallIf), .stall_mem(bStallMem), .busy(bBusy)
    );

    typedef struct {
        logic        r, ir;
        logic [15:0] ia;
        logic        mr, mw;
        logic [15:0] ma, md;
        logic        en, we;
        logic [15:0] ea, ew;
        logic        iak, mak, si, sm, bz;
        logic [15:0] ird, mrd;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(
        input logic r, input logic ir, input logic [15:0] ia,
        input logic mr, input logic mw, input logic [15:0] ma, input logic [15:0] md,
        input logic en, input logic we, input logic [15:0] ea, input logic [15:0] ew,
        input logic iak, input logic mak, input logic si, input logic sm, input logic bz,
        input logic [15:0] ird, input logic [15:0] mrd);
        vec_t v;
        v.r = r;   v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma; v.md = md;
        v.en = en; v.we = we; v.ea = ea; v.ew = ew;
        v.iak = iak; v.mak = mak; v.si = si; v.sm = sm; v.bz = bz;
        v.ird = ird; v.mrd = mrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    string seq;
    int    nAck;
    int    nMemAck;
    int    nEn;
    logic  sawIfAck;
    logic  sawStallDrop;

    initial begin
        rst = 1'b1; ifReq = 1'b0; ifAddr = '0; memReq = 1'b0; memWe = 1'b0;
        memAddr = '0; memWdata = '0;
        bRst = 1'b1; bIfReq = 1'b0; bIfAddr = '0; bMemReq = 1'b0; bMemWe = 1'b0;
        bMemAddr = '0; bMemWdata = '0;

        //           r  ir ia        mr mw ma        md         en we ea        ew         iak mak si sm bz ird       mrd
        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
        vecs[3]  = mk(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, 16'h0000);
        vecs[4]  = mk(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 1, 16'h0000, 16'h0000);
        vecs[5]  = mk(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 1, 0, 0, 0, 1, 16'hA5A5, 16'h0000);
        vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 16'hA5A5, 16'h0000);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 1, 0, 16'hA5A5, 16'h0000);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 1, 1, 16'hA5A5, 16'h0000);
        vecs[9]  = mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 1, 1, 16'h0020, 16'h1234, 0, 0, 0, 1, 1, 16'hA5A5, 16'h0000);
        vecs[10] = mk(0, 0, 16'h0000, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0020, 16'h0000, 0, 1, 0, 0, 1, 16'hA5A5, 16'h0000);
        vecs[11] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 16'hA5A5, 16'h0000);
        vecs[12] = mk(0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0020, 16'h0000, 0, 0, 0, 1, 0, 16'hA5A5, 16'h0000);
        vecs[13] = mk(0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 0, 1, 1, 16'hA5A5, 16'h0000);
        vecs[14] = mk(0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 0, 1, 1, 16'hA5A5, 16'h0000);
        vecs[15] = mk(0, 0, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 0, 16'h0030, 16'h0000, 0, 1, 0, 0, 1, 16'hA5A5, 16'hFFCF);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0030, 16'h0000, 0, 0, 0, 0, 0, 16'hA5A5, 16'hFFCF);

        repeat (2) @(negedge clk);
        bRst = 1'b0;

        // Per-cycle table: IF read, MEM write, MEM read
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = vecs[i].r; ifReq = vecs[i].ir; ifAddr = vecs[i].ia;
            memReq = vecs[i].mr; memWe = vecs[i].mw; memAddr = vecs[i].ma; memWdata = vecs[i].md;
            #1;
            chk($sformatf("vec%0d", i),
                64'({extEn, extWe, extAddr, ifAck, memAck, stallIf, stallMem, busy, ifRdata, memRdata}),
                64'({vecs[i].en, vecs[i].we, vecs[i].ea, vecs[i].iak, vecs[i].mak, vecs[i].si,
                     vecs[i].sm, vecs[i].bz, vecs[i].ird, vecs[i].mrd}));
            if (vecs[i].we) chk($sformatf("vec%0d_wdata", i), 64'(extWdata), 64'(vecs[i].ew));
        end

        // Starvation guard: both held, expect MMMIMMMI
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 16'h0040; memReq = 1'b1; memWe = 1'b0; memAddr = 16'h0050;
        seq = "";
        nAck = 0;
        for (int c = 0; c < 60 && nAck < 8; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (ifAck && memAck) chk("dual_ack", 64'(1), 64'(0));
            if (memAck) begin seq = {seq, "M"}; nAck++; end
            if (ifAck)  begin seq = {seq, "I"}; nAck++; end
        end
        tests++;
        if (seq != "MMMIMMMI") begin
            fails++;
            $display("FAIL starve_seq: got %s expected MMMIMMMI", seq);
        end
        chk("starve_if_rdata", 64'(ifRdata), 64'(16'hFFBF));
        chk("starve_mem_rdata", 64'(memRdata), 64'(16'hFFAF));
        @(negedge clk);
        ifReq = 1'b0; memReq = 1'b0;
        @(negedge clk);
        #1 chk("starve_idle", 64'({busy, stallIf, stallMem}), 64'(0));

        // Reset during the second ACCESS cycle of an IF read
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 16'h0010;          // t0
        @(negedge clk);                           // t1
        #1 chk("rst_t1_en", 64'(extEn), 64'(1));
        @(negedge clk);                           // t2
        rst = 1'b1;
        @(negedge clk);                           // t3
        rst = 1'b0;
        #1 chk("rst_t3", 64'({extEn, ifAck, memAck, busy, ifRdata, memRdata}), 64'({1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}));
        @(negedge clk);                           // t4
        #1 chk("rst_t4", 64'({extEn, ifAck}), 64'({1'b1, 1'b0}));
        @(negedge clk);                           // t5
        #1 chk("rst_t5", 64'({extEn, ifAck}), 64'({1'b1, 1'b0}));
        @(negedge clk);                           // t6
        #1 chk("rst_t6", 64'({extEn, ifAck, ifRdata}), 64'({1'b0, 1'b1, 16'hA5A5}));
        @(negedge clk);
        ifReq = 1'b0;

        // MEM_LAT=1 read: one ext_en cycle, ack the following cycle
        @(negedge clk);
        bIfReq = 1'b1; bIfAddr = 16'h0010;
        #1 chk("lat1_t0", 64'({bExtEn, bIfAck, bBusy}), 64'({1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        #1 chk("lat1_t1", 64'({bExtEn, bIfAck, bExtAddr}), 64'({1'b1, 1'b0, 16'h0010}));
        @(negedge clk);
        #1 chk("lat1_t2", 64'({bExtEn, bIfAck, bStallIf, bIfRdata}), 64'({1'b0, 1'b1, 1'b0, 16'hA5A5}));
        @(negedge clk);
        bIfReq = 1'b0;
        #1 chk("lat1_idle", 64'({bBusy, bExtEn}), 64'(0));

        // STARVE_LIM=0: MEM always wins, IF stays stalled
        @(negedge clk);
        bIfReq = 1'b1; bIfAddr = 16'h0070; bMemReq = 1'b1; bMemWe = 1'b0; bMemAddr = 16'h0080;
        nMemAck = 0; nEn = 0; sawIfAck = 1'b0; sawStallDrop = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (bMemAck) nMemAck++;
            if (bExtEn)  nEn++;
            if (bIfAck)  sawIfAck = 1'b1;
            if (!bStallIf) sawStallDrop = 1'b1;
        end
        chk("nostarve_mem_acks", 64'(nMemAck), 64'(10));
        chk("nostarve_en_cycles", 64'(nEn), 64'(10));
        chk("nostarve_if_ack", 64'(sawIfAck), 64'(0));
        chk("nostarve_stall_if", 64'(sawStallDrop), 64'(0));
        chk("nostarve_mem_rdata", 64'(bMemRdata), 64'(16'hFF7F));
        @(negedge clk);
        bIfReq = 1'b0; bMemReq = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported external memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Serialises the two requesters through a fixed-latency access sequence and returns read data with a one-cycle ack pulse.
- Drives per-port stall outputs to the pipeline control path, alongside the load-use stall logic.
- Priority: MEM port over IF port, with a starvation guard that eventually forces an IF grant.

Parameters:
- ADDR_W, 16, address width of both ports and the external bus
- DATA_W, 16, data width
- MEM_LAT, 2, cycles ext_en is held per access; legal range 1..15
- STARVE_LIM, 3, consecutive IF losses before IF wins a tie; 0 disables the guard; legal range 0..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF read request, held until if_ack
- if_addr  in  ADDR_W  IF read address
- if_rdata  out  DATA_W  IF read data, valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM request, held until mem_ack
- mem_we  in  1  1=write, 0=read
- mem_addr  in  ADDR_W  MEM address
- mem_wdata  in  DATA_W  MEM write data
- mem_rdata  out  DATA_W  MEM read data, valid when mem_ack=1
- mem_ack  out  1  one-cycle completion pulse for MEM
- ext_en  out  1  external memory enable
- ext_we  out  1  external write enable
- ext_addr  out  ADDR_W  external address
- ext_wdata  out  DATA_W  external write data
- ext_rdata  in  DATA_W  external read data, valid in the last ext_en cycle
- stall_if  out  1  if_req && !if_ack (combinational)
- stall_mem  out  1  mem_req && !mem_ack (combinational)
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at a rising edge) forces:
  - state=IDLE, owner=IF, cnt=0, starve=0
  - if_ack=0, mem_ack=0, ext_en=0, ext_we=0
  - ext_addr=0, ext_wdata=0, if_rdata=0, mem_rdata=0
- Reset mid-access abandons the transaction: no ack is issued, ext_en drops the cycle after the reset edge, and a held request is re-arbitrated from IDLE.
- States are IDLE, ACCESS and ACK.
- IDLE:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant MEM unless STARVE_LIM!=0 and starve==STARVE_LIM, in which case grant IF.
  - On any grant: latch owner, addr, wdata and we (we=0 for IF); set cnt=MEM_LAT-1; go to ACCESS.
- Starve counter:
  - Increments (saturating at 15) each time IF loses to MEM in IDLE.
  - Clears to 0 whenever IF is granted.
- ACCESS:
  - ext_en=1; ext_we/ext_addr/ext_wdata come from the latched registers and are stable for all MEM_LAT cycles.
  - cnt decrements each cycle.
  - When cnt==0: capture ext_rdata into the owner's rdata register (writes leave rdata unchanged), then go to ACK.
- ACK:
  - ext_en=0; the owner's ack=1 for exactly one cycle; then go to IDLE.
  - The requester must drop or change its req at the clock edge where it samples ack=1. Arbitration of the next request starts in the following IDLE cycle.
- Latency: req first seen in IDLE at cycle t:
  - ext_en=1 for cycles t+1..t+MEM_LAT
  - ack=1 at cycle t+MEM_LAT+1
  - next grant is possible at t+MEM_LAT+2
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- Request handling:
  - Requests arriving during ACCESS/ACK wait; they are never dropped.
  - Request inputs are ignored outside IDLE.
  - A req deasserted before its grant is simply not served.
- if_ack and mem_ack are never high in the same cycle. An ack is only issued to the latched owner.
- if_rdata/mem_rdata hold their last captured value between accesses.

Test Plan:
- Single IF read, MEM_LAT=2, ext memory returns 16'hA5A5 at addr 16'h0010; if_req at t0:
  - ext_en high t1..t2, ext_addr=16'h0010, ext_we=0
  - if_ack=1 at t3 only, if_rdata=16'hA5A5
  - stall_if=1 t0..t2 and 0 at t3
- MEM write addr 16'h0020, data 16'h1234 → ext_we=1, ext_wdata=16'h1234 held 2 cycles; mem_ack at t3; mem_rdata unchanged.
- if_req and mem_req both held continuously, STARVE_LIM=3, MEM re-requests each time after its ack:
  - grants are MEM,MEM,MEM,IF,MEM,MEM,MEM,IF…
  - starve counts 0→3 then clears on the IF grant
- STARVE_LIM=0, both requests held continuously → MEM always wins; if_ack never asserts; stall_if stays 1.
- rst=1 during the second ACCESS cycle of an IF read → next cycle ext_en=0, if_ack=0, busy=0; the held if_req is regranted and acked MEM_LAT+1 cycles after rst falls.
- MEM_LAT=1 read → ext_en high for exactly one cycle, ack the following cycle; req-to-ack = 2 cycles.
